// File: rtl/rsa_uart_sequencer.sv
// rsa_uart_sequencer: Avalon-MM master that shuttles bytes between the UART and the RSA-256 core.
// Loads modulus N and exponent d once after reset. It then loops forever:
//   receive a 32-byte ciphertext block, run the core, and send 31 result bytes.
// Optional build macro RSA_SEQ_DEBUG_EN drives debug_num as {phase/state, byte count, blocks done}.
// Without the macro, debug_num is constant zero.
module rsa_uart_sequencer #(
    parameter int unsigned KEY_BYTES   = 32,
    parameter int unsigned OUT_BYTES   = 31,
    parameter logic [4:0]  RX_BASE     = 5'd0,
    parameter logic [4:0]  TX_BASE     = 5'd1,
    parameter logic [4:0]  STATUS_BASE = 5'd2,
    parameter int unsigned RX_OK_BIT   = 7,
    parameter int unsigned TX_OK_BIT   = 6
) (
    input  logic         clk_clk,
    input  logic         reset_reset_n,
    output logic [4:0]   avm_address,
    output logic         avm_read,
    input  logic [31:0]  avm_readdata,
    output logic         avm_write,
    output logic [31:0]  avm_writedata,
    input  logic         avm_waitrequest,
    output logic         rsa_start,
    output logic [255:0] rsa_n,
    output logic [255:0] rsa_d,
    output logic [255:0] rsa_a,
    input  logic         rsa_finished,
    input  logic [255:0] rsa_m,
    output logic [31:0]  debug_num
);

    typedef enum logic [2:0] {
        S_QUERY_RX  = 3'd0,
        S_READ_RX   = 3'd1,
        S_WAIT_CALC = 3'd2,
        S_QUERY_TX  = 3'd3,
        S_WRITE_TX  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PH_N = 2'd0,
        PH_D = 2'd1,
        PH_C = 2'd2
    } phase_t;

    localparam logic [5:0] KEY_LAST = 6'(KEY_BYTES - 1);
    localparam logic [5:0] OUT_LAST = 6'(OUT_BYTES - 1);

    state_t       state;
    phase_t       phase;
    logic [5:0]   byte_cnt;
    // Result shift register. The MSB byte of rsa_m is never transmitted, so it is not stored.
    logic [247:0] out_sr;
    logic [7:0]   rx_byte;

    assign rx_byte = avm_readdata[7:0];

    // Upper rxdata bits and the dropped result byte are intentionally ignored
    logic unused_bits;
    assign unused_bits = &{1'b0, avm_readdata[31:8], rsa_m[255:248]};

    // Sequencer FSM. On the first cycle in a bus state it raises the request.
    // It holds the request until waitrequest drops, and acts on that completing cycle.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state         <= S_QUERY_RX;
            phase         <= PH_N;
            byte_cnt      <= '0;
            out_sr        <= '0;
            avm_address   <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
            rsa_start     <= 1'b0;
            rsa_n         <= '0;
            rsa_d         <= '0;
            rsa_a         <= '0;
        end else begin
            rsa_start <= 1'b0;
            case (state)
                S_QUERY_RX: begin
                    if (!avm_read) begin
                        avm_read    <= 1'b1;
                        avm_address <= STATUS_BASE;
                    end else if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        if (avm_readdata[RX_OK_BIT]) begin
                            state <= S_READ_RX;
                        end
                    end
                end

                S_READ_RX: begin
                    if (!avm_read) begin
                        avm_read    <= 1'b1;
                        avm_address <= RX_BASE;
                    end else if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        case (phase)
                            PH_N:    rsa_n <= {rsa_n[247:0], rx_byte};
                            PH_D:    rsa_d <= {rsa_d[247:0], rx_byte};
                            default: rsa_a <= {rsa_a[247:0], rx_byte};
                        endcase
                        if (byte_cnt == KEY_LAST) begin
                            byte_cnt <= '0;
                            case (phase)
                                PH_N: begin
                                    phase <= PH_D;
                                    state <= S_QUERY_RX;
                                end
                                PH_D: begin
                                    phase <= PH_C;
                                    state <= S_QUERY_RX;
                                end
                                default: begin
                                    rsa_start <= 1'b1;
                                    state     <= S_WAIT_CALC;
                                end
                            endcase
                        end else begin
                            byte_cnt <= byte_cnt + 6'd1;
                            state    <= S_QUERY_RX;
                        end
                    end
                end

                S_WAIT_CALC: begin
                    if (rsa_finished) begin
                        out_sr <= rsa_m[247:0];
                        state  <= S_QUERY_TX;
                    end
                end

                S_QUERY_TX: begin
                    if (!avm_read) begin
                        avm_read    <= 1'b1;
                        avm_address <= STATUS_BASE;
                    end else if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        if (avm_readdata[TX_OK_BIT]) begin
                            state <= S_WRITE_TX;
                        end
                    end
                end

                S_WRITE_TX: begin
                    if (!avm_write) begin
                        avm_write     <= 1'b1;
                        avm_address   <= TX_BASE;
                        avm_writedata <= {24'h000000, out_sr[247:240]};
                    end else if (!avm_waitrequest) begin
                        avm_write <= 1'b0;
                        out_sr    <= {out_sr[239:0], 8'h00};
                        if (byte_cnt == OUT_LAST) begin
                            byte_cnt <= '0;
                            state    <= S_QUERY_RX;
                        end else begin
                            byte_cnt <= byte_cnt + 6'd1;
                            state    <= S_QUERY_TX;
                        end
                    end
                end

                default: begin
                    state     <= S_QUERY_RX;
                    avm_read  <= 1'b0;
                    avm_write <= 1'b0;
                end
            endcase
        end
    end

`ifdef RSA_SEQ_DEBUG_EN
    logic [15:0] block_cnt;

    // Count blocks whose final tx byte has completed. The count wraps at 16 bits.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            block_cnt <= '0;
        end else if (state == S_WRITE_TX && avm_write && !avm_waitrequest && byte_cnt == OUT_LAST) begin
            block_cnt <= block_cnt + 16'd1;
        end
    end

    assign debug_num = {3'b000, phase, state, 2'b00, byte_cnt, block_cnt};
`else
    assign debug_num = '0;
`endif

endmodule
